// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg: shared MIPS-subset ISA definitions for the loader, the encoder
// and, going forward, the CPU control decoder.
package cpu_isa_pkg;

  // Mnemonic codes as presented on the loader's host interface
  typedef enum logic [4:0] {
    OPC_ADD  = 5'd0,
    OPC_SUB  = 5'd1,
    OPC_AND  = 5'd2,
    OPC_OR   = 5'd3,
    OPC_XOR  = 5'd4,
    OPC_SLL  = 5'd5,
    OPC_SRL  = 5'd6,
    OPC_SRA  = 5'd7,
    OPC_JR   = 5'd8,
    OPC_ADDI = 5'd9,
    OPC_ANDI = 5'd10,
    OPC_ORI  = 5'd11,
    OPC_XORI = 5'd12,
    OPC_LW   = 5'd13,
    OPC_SW   = 5'd14,
    OPC_BEQ  = 5'd15,
    OPC_BNE  = 5'd16,
    OPC_LUI  = 5'd17,
    OPC_J    = 5'd18,
    OPC_JAL  = 5'd19
  } mnemonic_e;

  // Loader FSM states
  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } loader_state_e;

  // R-type function codes
  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;
  localparam logic [5:0] FUNC_XOR = 6'b100110;
  localparam logic [5:0] FUNC_SLL = 6'b000000;
  localparam logic [5:0] FUNC_SRL = 6'b000010;
  localparam logic [5:0] FUNC_SRA = 6'b000011;
  localparam logic [5:0] FUNC_JR  = 6'b001000;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // Field positions (LSB of each field in the 32-bit word)
  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SA_LSB    = 6;
  localparam int FUNC_LSB  = 0;
  localparam int IMM_LSB   = 0;
  localparam int TGT_LSB   = 0;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sa,
                                         input logic [5:0] func);
    return {OP_RTYPE, rs, rt, rd, sa, func};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] target);
    return {op, target};
  endfunction

endpackage

// File: rtl/isa_encode.sv
// isa_encode: combinational mnemonic+fields to 32-bit MIPS word encoder.
// Unknown mnemonics encode as a nop and raise illegal.
module isa_encode
  import cpu_isa_pkg::*;
(
  input  logic [4:0]  opc,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  sa,
  input  logic [25:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  // Select the word layout per mnemonic; shifts drop rs, jr drops rt/rd/sa,
  // non-shift R-types drop sa, lui drops rs
  always_comb begin
    word    = 32'h0000_0000;
    illegal = 1'b0;
    case (opc)
      OPC_ADD:  word = r_word(rs, rt, rd, 5'd0, FUNC_ADD);
      OPC_SUB:  word = r_word(rs, rt, rd, 5'd0, FUNC_SUB);
      OPC_AND:  word = r_word(rs, rt, rd, 5'd0, FUNC_AND);
      OPC_OR:   word = r_word(rs, rt, rd, 5'd0, FUNC_OR);
      OPC_XOR:  word = r_word(rs, rt, rd, 5'd0, FUNC_XOR);
      OPC_SLL:  word = r_word(5'd0, rt, rd, sa, FUNC_SLL);
      OPC_SRL:  word = r_word(5'd0, rt, rd, sa, FUNC_SRL);
      OPC_SRA:  word = r_word(5'd0, rt, rd, sa, FUNC_SRA);
      OPC_JR:   word = r_word(rs, 5'd0, 5'd0, 5'd0, FUNC_JR);
      OPC_ADDI: word = i_word(OP_ADDI, rs, rt, imm[15:0]);
      OPC_ANDI: word = i_word(OP_ANDI, rs, rt, imm[15:0]);
      OPC_ORI:  word = i_word(OP_ORI,  rs, rt, imm[15:0]);
      OPC_XORI: word = i_word(OP_XORI, rs, rt, imm[15:0]);
      OPC_LW:   word = i_word(OP_LW,   rs, rt, imm[15:0]);
      OPC_SW:   word = i_word(OP_SW,   rs, rt, imm[15:0]);
      OPC_BEQ:  word = i_word(OP_BEQ,  rs, rt, imm[15:0]);
      OPC_BNE:  word = i_word(OP_BNE,  rs, rt, imm[15:0]);
      OPC_LUI:  word = i_word(OP_LUI,  5'd0, rt, imm[15:0]);
      OPC_J:    word = j_word(OP_J,   imm);
      OPC_JAL:  word = j_word(OP_JAL, imm);
      default: begin
        word    = 32'h0000_0000;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/isa_encode_loader.sv
// isa_encode_loader: encodes a stream of mnemonic instructions and writes them
// into the CPU instruction memory, holding the CPU in reset until done.
// Optional feature macro: LOADER_CHKSUM_EN enables the XOR checksum of written words.
module isa_encode_loader
  import cpu_isa_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opc,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_sa,
  input  logic [25:0]       in_imm,
  input  logic              in_last,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic              err,
  output logic [31:0]       chksum
);

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  loader_state_e   state;
  logic [ADDR_W:0] wr_cnt;
  logic [31:0]     enc_word;
  logic            enc_illegal;
  logic            accept;
  logic            at_top;

  isa_encode u_encode (
    .opc     (in_opc),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .sa      (in_sa),
    .imm     (in_imm),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  // Ready depends only on registered state, so there is no path from in_valid
  assign in_ready = (state == ST_LOAD) && !wr_cnt[ADDR_W];
  assign accept   = in_valid && in_ready;
  assign at_top   = (wr_cnt[ADDR_W-1:0] == {ADDR_W{1'b1}});

  // Loader FSM with the input register stage, write counter and sticky error
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= ST_LOAD;
      wr_cnt     <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0000_0000;
      cpu_run    <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (accept) begin
            imem_we    <= 1'b1;
            imem_addr  <= wr_cnt[ADDR_W-1:0];
            imem_wdata <= enc_word;
            wr_cnt     <= wr_cnt + CNT_ONE;
            if (enc_illegal) err <= 1'b1;
            if (in_last || at_top) state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          state   <= ST_DONE;
          cpu_run <= 1'b1;
        end
        ST_DONE: begin
          if (reload) begin
            state   <= ST_LOAD;
            wr_cnt  <= '0;
            err     <= 1'b0;
            cpu_run <= 1'b0;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

`ifdef LOADER_CHKSUM_EN
  // Fold every written word into the checksum; cleared when a reload restarts loading
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      chksum <= 32'h0000_0000;
    end else if (state == ST_DONE && reload) begin
      chksum <= 32'h0000_0000;
    end else if (imem_we) begin
      chksum <= chksum ^ imem_wdata;
    end
  end
`else
  assign chksum = 32'h0000_0000;
`endif

endmodule
